// File: rtl/hazard_controller.sv
// hazard_controller: EX-stage forwarding selects, load-use stall and
// taken-branch flush for a 5-stage pipeline. A shadow pipeline of
// {rd, write, load} tracks the EX, MEM and WB stages. The selects are
// registered so that they reach EX together with their instruction.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall and flush
// counters as outputs.
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SHADOW = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ext_hold,
  output logic [1:0]            srcA,
  output logic [1:0]            srcB,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  flush_if_id
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_count,
  output logic [31:0]           flush_count
`endif
);

  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } shadow_t;

  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_RF    = 2'b00;

  state_t  state_q, state_d;
  shadow_t sh_ex_q, sh_ex_d, sh_mem_q, sh_mem_d, sh_wb_q, sh_wb_d;
  logic [1:0] src_a_q, src_a_d, src_b_q, src_b_d;
  logic [1:0] fwd_a, fwd_b;
  logic       load_use;

  // A producer only counts if it writes a non-zero rd the consumer really reads.
  function automatic logic hit(input shadow_t p, input logic [REG_ADDR_W-1:0] idx,
                               input logic use_rs);
    return p.wr && (p.rd != '0) && (p.rd == idx) && use_rs;
  endfunction

  // Forwarding match, youngest producer first; WB needs none (write-first RF).
  always_comb begin
    fwd_a = hit(sh_ex_q, id_rs1, id_use_rs1) ? SEL_EXMEM :
            hit(sh_mem_q, id_rs1, id_use_rs1) ? SEL_MEMWB : SEL_RF;
    fwd_b = hit(sh_ex_q, id_rs2, id_use_rs2) ? SEL_EXMEM :
            hit(sh_mem_q, id_rs2, id_use_rs2) ? SEL_MEMWB : SEL_RF;
    load_use = id_valid && sh_ex_q.ld &&
               (hit(sh_ex_q, id_rs1, id_use_rs1) || hit(sh_ex_q, id_rs2, id_use_rs2));
  end

  // Next-state, control outputs and shadow shift; ext_hold freezes everything.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred;
    // blocking assignments here let the shadow shift see this cycle's bubble_ex.
    state_d     = state_q;
    stall_if_id = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    sh_ex_d     = sh_ex_q;
    sh_mem_d    = sh_mem_q;
    sh_wb_d     = sh_wb_q;
    if (!ext_hold) begin
      src_a_d = fwd_a;
      src_b_d = fwd_b;
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
            src_a_d     = SEL_RF;
            src_b_d     = SEL_RF;
            state_d     = FLUSH;
          end else if (load_use) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
            src_a_d     = SEL_RF;
            src_b_d     = SEL_RF;
            state_d     = LSTALL;
          end
        end
        LSTALL:  state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
      sh_wb_d  = sh_mem_q;
      sh_mem_d = sh_ex_q;
      sh_ex_d  = bubble_ex ? '0 :
                 '{rd: id_rd, wr: id_reg_write & id_valid, ld: id_mem_read & id_valid};
    end
  end

  // State, shadow and select registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state_q  <= RUN;
      sh_ex_q  <= '0;
      sh_mem_q <= '0;
      sh_wb_q  <= '0;
      src_a_q  <= SEL_RF;
      src_b_q  <= SEL_RF;
    end else begin
      state_q  <= state_d;
      sh_ex_q  <= sh_ex_d;
      sh_mem_q <= sh_mem_d;
      sh_wb_q  <= sh_wb_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
    end
  end

  assign srcA = src_a_q;
  assign srcB = src_b_q;

  // Sanity: three tracked stages and a fully defined shadow pipeline out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (NUM_SHADOW == 3);
      assert (!$isunknown(sh_wb_q));
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Saturating event counters; the control outputs are already 0 under ext_hold.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ext_hold && stall_if_id && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!ext_hold && flush_if_id && (flush_cnt_q != 32'hFFFF_FFFF))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a table of per-cycle ID-stage
// instructions with hand-computed outputs, then hand-written hold and
// reset sequences.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken, ext_hold;
  logic [1:0] srcA, srcB;
  logic       stall_if_id, bubble_ex, flush_if_id;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  hazard_controller dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .ext_hold(ext_hold),
    .srcA(srcA), .srcB(srcB), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, u1, u2, wr, mr, br;
    logic [4:0] rs1, rs2, rd;
    logic       e_stall, e_bub, e_flush;
    logic [1:0] e_a, e_b;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic [4:0] rd,
                              input logic wr, input logic mr, input logic br,
                              input logic st, input logic bu, input logic fl,
                              input logic [1:0] a, input logic [1:0] b);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2; t.rd = rd;
    t.wr = wr; t.mr = mr; t.br = br;
    t.e_stall = st; t.e_bub = bu; t.e_flush = fl; t.e_a = a; t.e_b = b;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_rd = t.rd; id_reg_write = t.wr; id_mem_read = t.mr; ex_branch_taken = t.br;
  endtask

  task automatic check_ctrl(input string tag, input logic st, input logic bu, input logic fl);
    check({tag, " stall_if_id"}, {31'd0, stall_if_id}, {31'd0, st});
    check({tag, " bubble_ex"},   {31'd0, bubble_ex},   {31'd0, bu});
    check({tag, " flush_if_id"}, {31'd0, flush_if_id}, {31'd0, fl});
  endtask

  // Called one time unit after a rising edge: drive, check combinational
  // outputs, clock, then check the registered selects.
  task automatic apply(input string tag, input vec_t t);
    drive(t);
    #2;
    check_ctrl(tag, t.e_stall, t.e_bub, t.e_flush);
    @(posedge clk);
    #1;
    check({tag, " srcA"}, {30'd0, srcA}, {30'd0, t.e_a});
    check({tag, " srcB"}, {30'd0, srcB}, {30'd0, t.e_b});
  endtask

  initial begin
    //               v rs1 rs2 u1 u2 rd wr mr br  st bu fl  a  b
    vecs[0]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0); // add x5,x1,x2
    vecs[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0,  0, 0, 0, 2, 0); // add x6,x5,x1: EX fwd
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // nop
    vecs[3]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0); // add x5
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // nop
    vecs[5]  = mk(1, 1, 5, 1, 1, 7, 1, 0, 0,  0, 0, 0, 0, 1); // sub x7,x1,x5: MEM fwd
    vecs[6]  = mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0); // lw x5
    vecs[7]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0,  1, 1, 0, 0, 0); // add x6,x5,x5: load-use
    vecs[8]  = mk(1, 5, 5, 1, 1, 6, 1, 0, 0,  0, 0, 0, 1, 1); // held in LSTALL
    vecs[9]  = mk(1, 1, 2, 1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0); // add x0,x1,x2
    vecs[10] = mk(1, 0, 0, 1, 1, 3, 1, 0, 0,  0, 0, 0, 0, 0); // add x3,x0,x0: no x0 fwd
    vecs[11] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0); // lw x5
    vecs[12] = mk(1, 5, 5, 1, 1, 6, 1, 0, 1,  0, 1, 1, 0, 0); // load-use + branch: flush wins
    vecs[13] = mk(1, 5, 5, 1, 1, 6, 1, 0, 0,  0, 0, 0, 1, 1); // FLUSH cycle: outputs 0
    vecs[14] = mk(1, 1, 0, 1, 0, 5, 1, 1, 0,  0, 0, 0, 0, 0); // lw x5
    vecs[15] = mk(1, 5, 0, 1, 0, 7, 1, 1, 0,  1, 1, 0, 0, 0); // lw x7,0(x5): load-use
    vecs[16] = mk(1, 5, 0, 1, 0, 7, 1, 1, 0,  0, 0, 0, 1, 0); // held
    vecs[17] = mk(1, 7, 5, 1, 1, 8, 1, 0, 0,  1, 1, 0, 0, 0); // back-to-back load-use
    vecs[18] = mk(1, 7, 5, 1, 1, 8, 1, 0, 0,  0, 0, 0, 1, 0); // held
    vecs[19] = mk(1, 8, 8, 0, 1, 8, 1, 0, 0,  0, 0, 0, 0, 2); // rs1 unused: no fwd on A
    vecs[20] = mk(1, 8, 0, 1, 0, 9, 1, 0, 0,  0, 0, 0, 2, 0); // EX and MEM match: EX wins

    rst_n = 1'b0;
    ext_hold = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check("reset srcA", {30'd0, srcA}, 32'd0);
    check("reset srcB", {30'd0, srcB}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("reset stall_count", stall_count, 32'd0);
    check("reset flush_count", flush_count, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) apply($sformatf("vec%0d", i), vecs[i]);

`ifdef HAZARD_PERF_CNT_EN
    check("stall_count", stall_count, 32'd3);
    check("flush_count", flush_count, 32'd1);
`endif

    // ext_hold for three cycles while srcA forwards from EX.
    apply("hold pre0", mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    apply("hold pre1", mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 2, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0)); // nop + branch, both frozen
    ext_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check_ctrl($sformatf("hold%0d", c), 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("hold%0d srcA", c), {30'd0, srcA}, 32'd2);
    end
    ext_hold = 1'b0;
    // Shadow must still be EX=x6, MEM=x5.
    apply("hold post", mk(1, 6, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1));

    // Reset while in LSTALL.
    apply("rst lw", mk(1, 1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
    apply("rst dep", mk(1, 5, 5, 1, 1, 6, 1, 0, 0, 1, 1, 0, 0, 0));
    ex_branch_taken = 1'b1;
    #1;
    check_ctrl("lstall ignores br", 1'b0, 1'b0, 1'b0);
    ex_branch_taken = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_ctrl("mid-reset", 1'b0, 1'b0, 1'b0);
    check("mid-reset srcA", {30'd0, srcA}, 32'd0);
    check("mid-reset srcB", {30'd0, srcB}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("mid-reset stall_count", stall_count, 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    // Shadow cleared (no stall for the same dependent ID) and state is RUN
    // (a branch now flushes).
    #1;
    check_ctrl("post-reset no stall", 1'b0, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    check_ctrl("post-reset RUN", 1'b0, 1'b1, 1'b1);
    ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
